aes_encrypt_core: RTL and testbench
===================================

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 SHALL have no parameters; AES-128 only (10 rounds, 128-bit key).
REQ-002 SHALL have port `Clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `Reset`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port `AES_START`, input, 1 bit: start request / handshake hold.
REQ-005 SHALL have port `AES_KEY`, input, 128 bits: cipher key, FIPS-197 byte 0 at [127:120].
REQ-006 SHALL have port `AES_MSG_PT`, input, 128 bits: plaintext, same byte order as `AES_KEY`.
REQ-007 SHALL have port `AES_DONE`, output, 1 bit: ciphertext valid.
REQ-008 SHALL have port `AES_MSG_ENC`, output, 128 bits: ciphertext register.

Function
REQ-009 SHALL implement FIPS-197 AES-128 encryption; state bytes are column-major, with byte i at bits [127-8i -: 8].
REQ-010 SHALL perform one transform per cycle, in this order:
- ARK0;
- rounds 1-9 as SUB, SHIFT, MIX, ARK;
- round 10 as SUB, SHIFT, ARK.
REQ-011 SHALL use these FSM states: IDLE, ARK0, SUB, SHIFT, MIX, ARK, DONE, plus a 4-bit round counter (1..10).
REQ-012 In IDLE with AES_START=1 at an edge, SHALL latch AES_MSG_PT into the state register and AES_KEY into the round-key register, set round=1 and go to ARK0; inputs are ignored at all other times.
REQ-013 Transitions SHALL be:
- ARK0->SUB; SUB->SHIFT;
- SHIFT->MIX if round<10, else SHIFT->ARK;
- MIX->ARK;
- ARK->SUB with round+1 if round<10, else ARK->DONE.
REQ-014 SHALL expand the key on the fly, one round key per round: the round-key register updates to key[round] on the SHIFT-state edge (RotWord, SubWord, Rcon[round], XOR chain) so that ARK uses it on the next cycle.
REQ-015 Rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-016 MixColumns SHALL use xtime with conditional 0x1B reduction, 8-bit wrap, with no carry out of any byte.
REQ-017 SubBytes and SubWord SHALL instantiate the team's combinational forward S-box module: 16 instances on the state, 4 on the key word.
REQ-018 Latency SHALL be 40 processing cycles: if START is sampled at edge N, AES_DONE=1 from edge N+41.
REQ-019 On entry to DONE, SHALL load AES_MSG_ENC with the final state and assert AES_DONE.
REQ-020 SHALL stay in DONE while AES_START=1; when AES_START=0 at an edge in DONE, SHALL go to IDLE and deassert AES_DONE.
REQ-021 AES_MSG_ENC SHALL hold its value until the next DONE entry or Reset.
REQ-022 AES_START held high continuously SHALL NOT retrigger; a new operation requires START low (IDLE) and then high again.
REQ-023 SHALL have a 1-cycle DONE-to-IDLE turnaround; START=1 sampled in the first IDLE cycle starts the next operation.

Reset
REQ-024 Reset=1 at any edge SHALL force state IDLE, round=0, AES_DONE=0, AES_MSG_ENC=0, and zero the state and key registers.
REQ-025 Reset SHALL take priority over every other event, including mid-operation and with START=1 at the same edge.
REQ-026 After Reset deasserts, START=1 SHALL be required in IDLE; a START held high through Reset SHALL start an operation on the first edge with Reset=0.

Configuration
REQ-027 Macro AES_ENC_ABORT_EN: when defined, AES_START=0 sampled in any processing state (ARK0..ARK) SHALL return to IDLE at that edge, with AES_DONE=0 and AES_MSG_ENC unchanged.
REQ-028 Without AES_ENC_ABORT_EN, AES_START SHALL be ignored from ARK0 until DONE is entered.

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f with PT 00112233445566778899aabbccddeeff, START held -> AES_DONE=1 exactly 41 edges after the START edge, and AES_MSG_ENC=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c with PT 3243f6a8885a308d313198a2e0370734 -> AES_MSG_ENC=3925841d02dc09fbdc118597196a0b32.
REQ-031 After REQ-029, hold START 10 more cycles, then drop it -> AES_DONE stays 1 until the START=0 edge, drops on the next edge, and no recomputation occurs.
REQ-032 Reset pulsed at processing cycle 20 -> next edge AES_DONE=0, AES_MSG_ENC=0, FSM in IDLE; re-START gives the correct ciphertext after 41 edges.
REQ-033 Change AES_KEY and AES_MSG_PT during processing -> ciphertext matches the values latched at the START edge.
REQ-034 With AES_ENC_ABORT_EN defined, drop START at cycle 15 -> IDLE next edge, AES_DONE never asserts, and the previous AES_MSG_ENC is retained; without the macro, the same stimulus -> normal completion at edge 41 with AES_DONE=1.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption, one transform per clock.
//
// Ports:
//   Clk          in   1    clock, rising edge
//   Reset        in   1    synchronous, active-high
//   AES_START    in   1    start request; held high through DONE as handshake
//   AES_KEY      in   128  cipher key, byte 0 at [127:120]
//   AES_MSG_PT   in   128  plaintext, byte 0 at [127:120]
//   AES_DONE     out  1    ciphertext valid
//   AES_MSG_ENC  out  128  ciphertext, held until next completion or Reset
//
// Build option: define AES_ENC_ABORT_EN to let AES_START=0 abort an
// operation in progress (back to IDLE, previous ciphertext kept).
//
// Also contains aes_sbox, the combinational forward S-box.
//
// state | meaning
// IDLE  | waiting for AES_START, latches key and plaintext
// ARK0  | initial AddRoundKey with the cipher key
// SUB   | SubBytes
// SHIFT | ShiftRows; round key advances to key[round]
// MIX   | MixColumns (rounds 1-9 only)
// ARK   | AddRoundKey; next round or finish
// DONE  | first cycle loads ciphertext, then waits for AES_START=0

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [2047:0] shifted;

    // Entry a sits at [2047-8a -: 8]; shifting it to the top avoids a
    // variable part-select.
    assign shifted = SBOX << {a, 3'b000};
    assign y       = shifted[2047:2040];
endmodule

module aes_encrypt_core (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_PT,
    output logic         AES_DONE,
    output logic [127:0] AES_MSG_ENC
);
    typedef enum logic [2:0] {IDLE, ARK0, SUB, SHIFT, MIX, ARK, DONE} state_t;

    state_t       state, next_state;
    logic [3:0]   round;
    logic [127:0] st, rk;
    logic [127:0] sub_st, shift_st, mix_st, key_next;
    logic [31:0]  rot_word, sub_word, key_t;
    logic [7:0]   rcon;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes, ShiftRows, MixColumns on the state register
    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sub_st[127-8*i -: 8]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shift_st[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
        end

        logic [7:0] a0, a1, a2, a3;
        assign a0 = st[127-32*c -: 8];
        assign a1 = st[119-32*c -: 8];
        assign a2 = st[111-32*c -: 8];
        assign a3 = st[103-32*c -: 8];
        assign mix_st[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

    // On-the-fly key expansion: key[round] from key[round-1]
    always_comb begin
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot_word = {rk[23:0], rk[31:24]};
    for (genvar k = 0; k < 4; k++) begin : g_key_sub
        aes_sbox u_sbox (.a(rot_word[31-8*k -: 8]), .y(sub_word[31-8*k -: 8]));
    end
    assign key_t              = sub_word ^ {rcon, 24'h000000};
    assign key_next[127:96]   = rk[127:96] ^ key_t;
    assign key_next[95:64]    = rk[95:64]  ^ key_next[127:96];
    assign key_next[63:32]    = rk[63:32]  ^ key_next[95:64];
    assign key_next[31:0]     = rk[31:0]   ^ key_next[63:32];

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (AES_START) next_state = ARK0;
            ARK0:    next_state = SUB;
            SUB:     next_state = SHIFT;
            SHIFT:   next_state = (round < 4'd10) ? MIX : ARK;
            MIX:     next_state = ARK;
            ARK:     next_state = (round < 4'd10) ? SUB : DONE;
            // The ciphertext is loaded on the first DONE edge, so leaving
            // is only possible once AES_DONE is already up.
            DONE:    if (AES_DONE && !AES_START) next_state = IDLE;
            default: next_state = IDLE;
        endcase
`ifdef AES_ENC_ABORT_EN
        if (state != IDLE && state != DONE && !AES_START) next_state = IDLE;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            round       <= 4'd0;
            st          <= '0;
            rk          <= '0;
            AES_DONE    <= 1'b0;
            AES_MSG_ENC <= '0;
        end else begin
            case (state)
                IDLE: if (AES_START) begin
                    st    <= AES_MSG_PT;
                    rk    <= AES_KEY;
                    round <= 4'd1;
                end
                ARK0:  st <= st ^ rk;
                SUB:   st <= sub_st;
                SHIFT: begin
                    st <= shift_st;
                    rk <= key_next;
                end
                MIX:   st <= mix_st;
                ARK: begin
                    st <= st ^ rk;
                    if (round < 4'd10) round <= round + 4'd1;
                end
                DONE: begin
                    if (!AES_DONE) begin
                        AES_MSG_ENC <= st;
                        AES_DONE    <= 1'b1;
                    end else if (!AES_START) begin
                        AES_DONE    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_core.sv
module tb_aes_encrypt_core;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key, pt;
    logic         done;
    logic [127:0] ct;

    int checks = 0;
    int errors = 0;

    aes_encrypt_core dut (
        .Clk(clk), .Reset(reset), .AES_START(start), .AES_KEY(key),
        .AES_MSG_PT(pt), .AES_DONE(done), .AES_MSG_ENC(ct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Raises START, takes edge N, then counts edges until AES_DONE shows.
    // lat=0 means AES_DONE never appeared within the budget.
    task automatic run_op(input logic [127:0] k, input logic [127:0] p,
                          input int drop_at, input bit scramble, output int lat);
        key   = k;
        pt    = p;
        start = 1'b1;
        tick();
        if (scramble) begin
            key = ~k;
            pt  = p ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
        end
        lat = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == drop_at) start = 1'b0;
            tick();
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int hold_bad;
        logic [127:0] prev_ct;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h00000000000000000000000000000000,
                    128'h00000000000000000000000000000000,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};

        reset = 1'b1;
        start = 1'b0;
        key   = '0;
        pt    = '0;
        tick();
        tick();
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_ct", ct, 128'd0);
        reset = 1'b0;
        tick();
        chk("idle_no_start", {127'd0, done}, 128'd0);

        // Back-to-back vectors; each restart lands in the first IDLE cycle
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].key, vecs[i].pt, 0, 1'b0, lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd41);
            chk($sformatf("vec%0d_ct", i), ct, vecs[i].ct);
            start = 1'b0;
            tick();
            chk($sformatf("vec%0d_done_drop", i), {127'd0, done}, 128'd0);
            chk($sformatf("vec%0d_ct_hold", i), ct, vecs[i].ct);
        end

        // START held through DONE: no retrigger, DONE stays until START=0
        run_op(vecs[0].key, vecs[0].pt, 0, 1'b0, lat);
        chk("hold_latency", 128'(lat), 128'd41);
        hold_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done !== 1'b1 || ct !== vecs[0].ct) hold_bad++;
        end
        chk("hold_done_stays", 128'(hold_bad), 128'd0);
        start = 1'b0;
        tick();
        chk("hold_done_drop", {127'd0, done}, 128'd0);
        repeat (5) tick();
        chk("hold_no_recompute", {127'd0, done}, 128'd0);
        chk("hold_ct_kept", ct, vecs[0].ct);

        // Reset mid-operation with START still high
        key   = vecs[1].key;
        pt    = vecs[1].pt;
        start = 1'b1;
        tick();
        repeat (19) tick();
        reset = 1'b1;
        tick();
        chk("midreset_done", {127'd0, done}, 128'd0);
        chk("midreset_ct", ct, 128'd0);
        reset = 1'b0;
        run_op(vecs[1].key, vecs[1].pt, 0, 1'b0, lat);
        chk("after_reset_latency", 128'(lat), 128'd41);
        chk("after_reset_ct", ct, vecs[1].ct);
        start = 1'b0;
        tick();

        // Inputs changed while processing must not matter
        run_op(vecs[2].key, vecs[2].pt, 0, 1'b1, lat);
        chk("scramble_latency", 128'(lat), 128'd41);
        chk("scramble_ct", ct, vecs[2].ct);
        start = 1'b0;
        tick();

        // START dropped at processing cycle 15
        prev_ct = ct;
        run_op(vecs[3].key, vecs[3].pt, 15, 1'b0, lat);
`ifdef AES_ENC_ABORT_EN
        chk("drop15_no_done", 128'(lat), 128'd0);
        chk("drop15_ct_kept", ct, prev_ct);
`else
        chk("drop15_latency", 128'(lat), 128'd41);
        chk("drop15_ct", ct, vecs[3].ct);
`endif
        start = 1'b0;
        tick();
        tick();
        chk("final_idle", {127'd0, done}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
